bin2bcd_seq: RTL and testbench

- Parametrised, handshaked, multi-cycle double-dabble (shift-add-3) converter: unsigned BIN_W-bit binary in, DIGITS packed BCD digits out.
- One input bit is processed per clock, so a conversion takes BIN_W cycles.
- Used ahead of the 7-segment / display-mux path wherever a counter or sensor value needs decimal display.
- Adds start/busy/done handshake, result hold and overflow detection.

---
 rtl/bin2bcd_seq.sv | 143 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Optional two's-complement input with a sign output: define BIN2BCD_SIGNED_EN.
module bin2bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                sign
`endif
);

    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state, state_nx;
    logic [BIN_W-1:0]   opnd, opnd_nx, opnd_ld;
    logic [BCD_W-1:0]   scr, scr_nx, scr_adj;
    logic [BCD_W-1:0]   bcd_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               sticky, sticky_nx;
    logic               ovf_nx, done_nx;
`ifdef BIN2BCD_SIGNED_EN
    logic               neg_cap, neg_cap_nx, sign_nx;
`endif

    // Handshake: start is sampled only while idle (busy=0); the edge that
    // samples it also captures bin. busy stays high for BIN_W cycles, then
    // done pulses for one cycle together with the bcd/ovf update. start may
    // be held during that done cycle and is accepted at the following edge.
    assign busy = (state == SHIFT);

`ifdef BIN2BCD_SIGNED_EN
    assign opnd_ld = bin[BIN_W-1] ? (~bin + BIN_W'(1)) : bin;
`else
    assign opnd_ld = bin;
`endif

    // Every digit >= 5 gets +3 so that the following shift carries into the next digit.
    always_comb begin
        scr_adj = scr;
        for (int k = 0; k < DIGITS; k++) begin
            if (scr[4*k +: 4] >= 4'd5) begin
                scr_adj[4*k +: 4] = scr[4*k +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        opnd_nx   = opnd;
        scr_nx    = scr;
        sticky_nx = sticky;
        cnt_nx    = cnt;
        done_nx   = 1'b0;
        bcd_nx    = bcd;
        ovf_nx    = ovf;
`ifdef BIN2BCD_SIGNED_EN
        neg_cap_nx = neg_cap;
        sign_nx    = sign;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = SHIFT;
                    opnd_nx   = opnd_ld;
                    scr_nx    = '0;
                    sticky_nx = 1'b0;
                    cnt_nx    = CNT_W'(BIN_W);
`ifdef BIN2BCD_SIGNED_EN
                    neg_cap_nx = bin[BIN_W-1];
`endif
                end
            end
            SHIFT: begin
                opnd_nx   = {opnd[BIN_W-2:0], 1'b0};
                scr_nx    = {scr_adj[BCD_W-2:0], opnd[BIN_W-1]};
                sticky_nx = sticky | scr_adj[BCD_W-1];
                cnt_nx    = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                    bcd_nx   = scr_nx;
                    ovf_nx   = sticky_nx;
`ifdef BIN2BCD_SIGNED_EN
                    sign_nx  = neg_cap;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opnd   <= '0;
            scr    <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            bcd    <= '0;
            ovf    <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            neg_cap <= 1'b0;
            sign    <= 1'b0;
`endif
        end else begin
            opnd   <= opnd_nx;
            scr    <= scr_nx;
            sticky <= sticky_nx;
            cnt    <= cnt_nx;
            done   <= done_nx;
            bcd    <= bcd_nx;
            ovf    <= ovf_nx;
`ifdef BIN2BCD_SIGNED_EN
            neg_cap <= neg_cap_nx;
            sign    <= sign_nx;
`endif
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: 8b/3-digit, 16b/5-digit and 8b/2-digit instances.
// Expected values follow the build: signed results when BIN2BCD_SIGNED_EN is defined.
module tb_bin2bcd_seq;

`ifdef BIN2BCD_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        start8 = 1'b0, busy8, done8, ovf8;
    logic [7:0]  bin8 = '0;
    logic [11:0] bcd8;
    logic        start16 = 1'b0, busy16, done16, ovf16;
    logic [15:0] bin16 = '0;
    logic [19:0] bcd16;
    logic        start2 = 1'b0, busy2, done2, ovf2;
    logic [7:0]  bin2 = '0;
    logic [7:0]  bcd2;
`ifdef BIN2BCD_SIGNED_EN
    logic        sign8, sign16, sign2;
`endif

    // {expected sign, expected bcd} for each accepted conversion on the 8b/3-digit unit
    logic [12:0] exp_q[$];
    logic [12:0] exp_e;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .bin(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8), .ovf(ovf8)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign8)
`endif
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .bin(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16), .ovf(ovf16)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign16)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
`ifdef BIN2BCD_SIGNED_EN
        , .sign(sign2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every done on the 3-digit unit must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && done8) begin
            if (exp_q.size() == 0) begin
                check("spurious_done8", 32'(done8), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("bcd8", 32'(bcd8), 32'(exp_e[11:0]));
                check("ovf8", 32'(ovf8), 32'd0);
`ifdef BIN2BCD_SIGNED_EN
                check("sign8", 32'(sign8), 32'(exp_e[12]));
`endif
            end
        end
    end

    // One conversion on the 3-digit unit; inj>0 re-pulses start (bin=42) in that busy cycle.
    task automatic conv8(input logic [7:0] v, input logic [11:0] e, input logic es, input int inj);
        int n, nb;
        @(negedge clk);
        start8 = 1'b1;
        bin8   = v;
        exp_q.push_back({es, e});
        @(negedge clk);
        start8 = 1'b0;
        bin8   = 8'($urandom_range(0, 255));
        n  = 1;
        nb = 0;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            if (n == inj) begin
                start8 = 1'b1;
                bin8   = 8'd42;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check("latency8", 32'(n), 32'd9);
        check("busy8_cycles", 32'(nb), 32'd8);
        check("busy8_at_done", 32'(busy8), 32'd0);
        @(negedge clk);
        check("done8_width", 32'(done8), 32'd0);
    endtask

    task automatic conv16(input logic [15:0] v, input logic [19:0] e, input logic es);
        int n;
        @(negedge clk);
        start16 = 1'b1;
        bin16   = v;
        @(negedge clk);
        start16 = 1'b0;
        n = 1;
        while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("latency16", 32'(n), 32'd17);
        check("bcd16", 32'(bcd16), 32'(e));
        check("ovf16", 32'(ovf16), 32'd0);
`ifdef BIN2BCD_SIGNED_EN
        check("sign16", 32'(sign16), 32'(es));
`else
        if (es) check("sign16_unsigned_build", 32'(es), 32'd0);
`endif
    endtask

    task automatic conv2(input logic [7:0] v, input logic [7:0] e, input logic eo, input logic es);
        int n;
        @(negedge clk);
        start2 = 1'b1;
        bin2   = v;
        @(negedge clk);
        start2 = 1'b0;
        n = 1;
        while (!done2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency2", 32'(n), 32'd9);
        check("bcd2", 32'(bcd2), 32'(e));
        check("ovf2", 32'(ovf2), 32'(eo));
`ifdef BIN2BCD_SIGNED_EN
        check("sign2", 32'(sign2), 32'(es));
`else
        if (es) check("sign2_unsigned_build", 32'(es), 32'd0);
`endif
        repeat (3) @(negedge clk);
        check("bcd2_hold", 32'(bcd2), 32'(e));
        check("ovf2_hold", 32'(ovf2), 32'(eo));
    endtask

    initial begin
        int n;
        #12;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_bcd8", 32'(bcd8), 32'd0);
        check("rst_ovf8", 32'(ovf8), 32'd0);
        check("rst_bcd16", 32'(bcd16), 32'd0);
        check("rst_ovf2", 32'(ovf2), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        conv8(8'd255, SGN ? 12'h001 : 12'h255, SGN, 0);

        // back-to-back: start held high through the first done
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd0;
        exp_q.push_back({1'b0, 12'h000});
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_latency", 32'(n), 32'd9);
        bin8 = 8'd9;
        exp_q.push_back({1'b0, 12'h009});
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_spacing", 32'(n), 32'd9);
        @(negedge clk);

        conv8(8'd137, SGN ? 12'h119 : 12'h137, SGN, 3);
        repeat (12) @(negedge clk);

        // reset in the 4th busy cycle abandons the conversion
        @(negedge clk);
        start8 = 1'b1;
        bin8   = 8'd200;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy8", 32'(busy8), 32'd0);
        check("midrst_done8", 32'(done8), 32'd0);
        check("midrst_bcd8", 32'(bcd8), 32'd0);
        check("midrst_ovf8", 32'(ovf8), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) n++;
        end
        check("no_done_after_rst", 32'(n), 32'd0);
        conv8(8'd200, SGN ? 12'h056 : 12'h200, SGN, 0);

        conv8(8'h80, 12'h128, SGN, 0);
        conv8(8'hFF, SGN ? 12'h001 : 12'h255, SGN, 0);
        conv8(8'h7F, 12'h127, 1'b0, 0);

        conv16(16'd65535, SGN ? 20'h00001 : 20'h65535, SGN);
        conv16(16'd12345, 20'h12345, 1'b0);

        conv2(8'd200, SGN ? 8'h56 : 8'h00, SGN ? 1'b0 : 1'b1, SGN);
        conv2(8'd99, 8'h99, 1'b0, 1'b0);
        conv2(8'd100, 8'h00, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
